ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the single-register control decoder: decodes opcode/func into a control bundle and carries it through the EX, MEM and WB stages with per-stage valid bits.
- Adds an input valid/ready handshake, global stall, branch flush, load-use hazard detection with bubble insertion, and a saturating stall counter.
- Sits between instruction fetch/decode and the datapath. The datapath reads each stage's controls from this block instead of re-registering them itself.

Parameters:
- OP_W, 4, opcode width
- FUNC_W, 4, func field width
- ALU_OP_W, 6, ALU op width; must be >= FUNC_W+2
- REG_AW, 4, register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode slot holds an instruction
- in_ready  out  1  block accepts the instruction this cycle
- opcode  in  OP_W  opcode
- func  in  FUNC_W  function field
- rs  in  REG_AW  source register 1
- rt  in  REG_AW  source register 2
- rd  in  REG_AW  destination register
- stall  in  1  downstream freeze (memory wait)
- flush  in  1  branch taken; kill EX stage and decode slot
- ex_valid  out  1  EX stage valid
- ex_alu_op  out  ALU_OP_W  ALU operation
- ex_alu_src  out  1  ALU uses immediate
- ex_br  out  1  branch instruction
- mem_valid  out  1  MEM stage valid
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- wb_valid  out  1  WB stage valid
- wb_reg_src  out  1  write-back source select
- wb_reg_write  out  1  register write enable (already gated by wb_valid)
- wb_rd  out  REG_AW  destination register
- stall_count  out  CNT_W  hazard bubbles inserted, saturating
- illegal_op  out  1  one-cycle pulse (feature only)

Behaviour:
- Reset (async, reset_n=0): every valid, control, alu_op, wb_rd and stall_count is 0; illegal_op is 0.

Decode table (opcode → reg_src, br, mem_read, mem_write, alu_src, reg_write; alu_op):

| Opcode | Value | reg_src | br | mem_read | mem_write | alu_src | reg_write | alu_op |
|---|---|---|---|---|---|---|---|---|
| ALUR | 0 | 0 | 0 | 0 | 0 | 0 | 1 | func |
| ALUI | 8 | 0 | 0 | 0 | 0 | 1 | 1 | func |
| LW | 9 | 0 | 0 | 1 | 0 | 1 | 1 | func |
| SW | 5 | 1 | 0 | 0 | 1 | 1 | 0 | func |
| CMPR | 2 | 0 | 0 | 0 | 0 | 0 | 1 | 16+func |
| CMPI | 10 | 0 | 0 | 0 | 0 | 1 | 1 | 16+func |
| BRANCH | 6 | 1 | 1 | 0 | 0 | 0 | 0 | 16+func |
| JAL | 11 | 0 | 0 | 0 | 0 | 1 | 1 | 32 |

- Any other opcode is illegal and decodes to a bubble (all controls 0).
- func is zero-extended to ALU_OP_W before any addition.

Latency and handshake:
- Accept = in_valid & in_ready & !stall & !flush.
- An instruction accepted at cycle t appears on ex_* at t+1, mem_* at t+2, wb_* at t+3.

Hazard rules:
- rs is used by all opcodes except JAL.
- rt is used by ALUR, CMPR, SW and BRANCH.
- hazard = ex_valid & EX.mem_read & EX.rd != 0 & (EX.rd == a used rs or rt).
- in_ready = !hazard.

Per-cycle update priority:
1. stall=1: all stages hold; flush is ignored this cycle; the counter holds.
2. Otherwise, flush=1: EX loads a bubble, MEM and WB advance, and the decode instruction is not accepted.
3. Otherwise, hazard: EX loads a bubble, MEM and WB advance, and stall_count increments (saturates at all-ones).
4. Otherwise, EX loads the decoded instruction if accepted, else a bubble; MEM and WB advance.

Other rules:
- Bubbles carry valid=0 and all controls 0.
- Outputs are raw stage registers, except wb_reg_write, which is ANDed with wb_valid.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - An accepted illegal opcode pulses illegal_op for one cycle, at the same cycle it would have entered EX.
  - The instruction still becomes a bubble.
- ILLEGAL_TRAP_EN undefined: illegal_op is tied to 0 and illegal opcodes are silently bubbled.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (ALUR … JAL)
  - CMP_OFFSET=16, JAL_ALU_OP=32
  - a packed struct ctrl_t {reg_src, br, mem_read, mem_write, alu_src, reg_write, alu_op, rd}
- One sub-module, ctrl_decode: purely combinational opcode/func → ctrl_t plus uses_rs, uses_rt and illegal.
- ctrl_pipe holds the stage registers, hazard logic and counter.

Test Plan:
- Reset then ALUI(op 8, func 3, rd 5): ex_alu_op=3 and alu_src=1 at t+1; wb_reg_write=1 and wb_rd=5 at t+3.
- LW rd=4, then ALUR rs=4: in_ready=0 for one cycle, one EX bubble, stall_count=1; ALUR reaches EX two cycles after the LW.
- LW rd=0, then ALUR rs=0: no hazard, no bubble, stall_count stays 0.
- BRANCH(op 6, func 2) in EX, then flush with ADD presented: ex_alu_op=18 first; the next EX is a bubble, the ADD is not accepted and is re-accepted once flush drops.
- stall held high 3 cycles mid-stream: all ex/mem/wb outputs are frozen; flush asserted during the stall has no effect.
- Opcode 15 with ILLEGAL_TRAP_EN: illegal_op pulses once and ex_valid=0; without the macro, illegal_op stays 0.
- reset_n asserted mid-stream: all valids drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control pipeline: opcodes, ALU op offsets
// and the per-stage control bundles.
package ctrl_pkg;

    localparam int CTRL_ALU_OP_W = 6;
    localparam int CTRL_REG_AW   = 4;

    localparam int OP_ALUR   = 0;
    localparam int OP_ALUI   = 8;
    localparam int OP_LW     = 9;
    localparam int OP_SW     = 5;
    localparam int OP_CMPR   = 2;
    localparam int OP_CMPI   = 10;
    localparam int OP_BRANCH = 6;
    localparam int OP_JAL    = 11;

    localparam int CMP_OFFSET = 16;
    localparam int JAL_ALU_OP = 32;

    typedef struct packed {
        logic                     reg_src;
        logic                     br;
        logic                     mem_read;
        logic                     mem_write;
        logic                     alu_src;
        logic                     reg_write;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic [CTRL_REG_AW-1:0]   rd;
    } ctrl_t;

    // Later stages only keep the fields still consumed downstream.
    typedef struct packed {
        logic                   reg_src;
        logic                   mem_read;
        logic                   mem_write;
        logic                   reg_write;
        logic [CTRL_REG_AW-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic                   reg_src;
        logic                   reg_write;
        logic [CTRL_REG_AW-1:0] rd;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/func decoder: produces the control bundle plus which
// source registers the instruction reads and whether the opcode is illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 4,
    parameter int REG_AW = 4
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic [REG_AW-1:0] rd,
    output ctrl_t             ctrl,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic              illegal
);

    logic [CTRL_ALU_OP_W-1:0] func_ext;
    logic [CTRL_ALU_OP_W-1:0] func_cmp;

    // Zero-extend first so the compare offset never wraps into func bits.
    assign func_ext = CTRL_ALU_OP_W'(func);
    assign func_cmp = func_ext + CTRL_ALU_OP_W'(CMP_OFFSET);

    always_comb begin
        ctrl    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_W'(OP_ALUR): begin
                ctrl.reg_write = 1'b1; ctrl.alu_op = func_ext;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_W'(OP_ALUI): begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = func_ext;
                uses_rs = 1'b1;
            end
            OP_W'(OP_LW): begin
                ctrl.mem_read = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.alu_op = func_ext;
                uses_rs = 1'b1;
            end
            OP_W'(OP_SW): begin
                ctrl.reg_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = func_ext;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_W'(OP_CMPR): begin
                ctrl.reg_write = 1'b1; ctrl.alu_op = func_cmp;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_W'(OP_CMPI): begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_op = func_cmp;
                uses_rs = 1'b1;
            end
            OP_W'(OP_BRANCH): begin
                ctrl.reg_src = 1'b1; ctrl.br = 1'b1; ctrl.alu_op = func_cmp;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_W'(OP_JAL): begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.alu_op = CTRL_ALU_OP_W'(JAL_ALU_OP);
            end
            default: illegal = 1'b1;
        endcase
        if (!illegal) ctrl.rd = CTRL_REG_AW'(rd);
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline EX/MEM/WB with handshake, stall, flush, load-use bubbles and
// a saturating bubble counter. Define ILLEGAL_TRAP_EN to pulse illegal_op.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int FUNC_W   = 4,
    parameter int ALU_OP_W = 6,
    parameter int REG_AW   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic [REG_AW-1:0]   rs,
    input  logic [REG_AW-1:0]   rt,
    input  logic [REG_AW-1:0]   rd,
    input  logic                stall,
    input  logic                flush,
    output logic                ex_valid,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_br,
    output logic                mem_valid,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_valid,
    output logic                wb_reg_src,
    output logic                wb_reg_write,
    output logic [REG_AW-1:0]   wb_rd,
    output logic [CNT_W-1:0]    stall_count,
    output logic                illegal_op
);

    localparam int STAGES = 3;

    ctrl_t     dec, ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;
    logic      uses_rs, uses_rt, dec_illegal;
    logic      hazard, accept, ex_in_vld;
    logic [STAGES:1] vld_pipe;   // 1=EX, 2=MEM, 3=WB

    ctrl_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W), .REG_AW(REG_AW)) u_dec (
        .opcode  (opcode),
        .func    (func),
        .rd      (rd),
        .ctrl    (dec),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .illegal (dec_illegal)
    );

    assign hazard = vld_pipe[1] & ex_q.mem_read & (ex_q.rd != '0) &
                    ((uses_rs & (ex_q.rd == CTRL_REG_AW'(rs))) |
                     (uses_rt & (ex_q.rd == CTRL_REG_AW'(rt))));
    assign in_ready  = !hazard;
    assign accept    = in_valid & in_ready & !stall & !flush;
    assign ex_in_vld = accept & !dec_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe    <= '0;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], ex_in_vld};
            ex_q     <= ex_in_vld ? dec : '0;
            mem_q    <= '{reg_src: ex_q.reg_src, mem_read: ex_q.mem_read,
                          mem_write: ex_q.mem_write, reg_write: ex_q.reg_write, rd: ex_q.rd};
            wb_q     <= '{reg_src: mem_q.reg_src, reg_write: mem_q.reg_write, rd: mem_q.rd};
            if (!flush && hazard && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) illegal_op <= 1'b0;
        else          illegal_op <= accept & dec_illegal;
    end
`else
    assign illegal_op = 1'b0;
`endif

    assign ex_valid     = vld_pipe[1];
    assign ex_alu_op    = ALU_OP_W'(ex_q.alu_op);
    assign ex_alu_src   = ex_q.alu_src;
    assign ex_br        = ex_q.br;
    assign mem_valid    = vld_pipe[2];
    assign mem_read     = mem_q.mem_read;
    assign mem_write    = mem_q.mem_write;
    assign wb_valid     = vld_pipe[3];
    assign wb_reg_src   = wb_q.reg_src;
    assign wb_reg_write = wb_q.reg_write & vld_pipe[3];
    assign wb_rd        = REG_AW'(wb_q.rd);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode, latency, load-use bubbles, flush,
// stall freeze, illegal opcode handling and asynchronous reset.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [3:0]  opcode, func, rs, rt, rd;
    logic        stall, flush;
    logic        ex_valid, ex_alu_src, ex_br;
    logic [5:0]  ex_alu_op;
    logic        mem_valid, mem_read, mem_write;
    logic        wb_valid, wb_reg_src, wb_reg_write;
    logic [3:0]  wb_rd;
    logic [15:0] stall_count;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_br(ex_br),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .wb_valid(wb_valid), .wb_reg_src(wb_reg_src), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .stall_count(stall_count), .illegal_op(illegal_op)
    );

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 0; opcode = 0; func = 0; rs = 0; rt = 0; rd = 0;
        stall = 0; flush = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] f,
                         input logic [3:0] s, input logic [3:0] t, input logic [3:0] d);
        in_valid = 1; opcode = op; func = f; rs = s; rt = t; rd = d;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        #2;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        total++; if (ex_alu_op !== 6'd0) begin bad++; $display("FAIL reset_alu_op got=%0d exp=0", ex_alu_op); end
        total++; if (wb_rd !== 4'd0) begin bad++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal_op got=%b exp=0", illegal_op); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        reset_n = 1;
        step();
    endtask

    task automatic test_alui_latency();
        drive(4'd8, 4'd3, 4'd1, 4'd0, 4'd5);
        step();
        idle();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL alui_ex_valid got=%b exp=1", ex_valid); end
        total++; if (ex_alu_op !== 6'd3) begin bad++; $display("FAIL alui_ex_alu_op got=%0d exp=3", ex_alu_op); end
        total++; if (ex_alu_src !== 1'b1) begin bad++; $display("FAIL alui_ex_alu_src got=%b exp=1", ex_alu_src); end
        step();
        total++; if (mem_valid !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL alui_mem got=%b%b exp=10", mem_valid, mem_read); end
        step();
        total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL alui_wb_reg_write got=%b exp=1", wb_reg_write); end
        total++; if (wb_rd !== 4'd5) begin bad++; $display("FAIL alui_wb_rd got=%0d exp=5", wb_rd); end
        step();
        total++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin bad++; $display("FAIL alui_wb_drain got=%b%b exp=00", wb_valid, wb_reg_write); end
    endtask

    task automatic test_load_use();
        drive(4'd9, 4'd0, 4'd1, 4'd0, 4'd4);
        step();
        drive(4'd0, 4'd7, 4'd4, 4'd2, 4'd6);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_in_ready got=%b exp=0", in_ready); end
        step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_stall_count got=%0d exp=1", stall_count); end
        total++; if (mem_valid !== 1'b1 || mem_read !== 1'b1) begin bad++; $display("FAIL lu_mem_lw got=%b%b exp=11", mem_valid, mem_read); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_ready_again got=%b exp=1", in_ready); end
        step();
        idle();
        total++; if (ex_valid !== 1'b1 || ex_alu_op !== 6'd7) begin bad++; $display("FAIL lu_alur_ex got=%b/%0d exp=1/7", ex_valid, ex_alu_op); end
        total++; if (wb_valid !== 1'b1 || wb_rd !== 4'd4) begin bad++; $display("FAIL lu_wb_lw got=%b/%0d exp=1/4", wb_valid, wb_rd); end
        repeat (3) step();
    endtask

    task automatic test_load_r0();
        drive(4'd9, 4'd0, 4'd1, 4'd0, 4'd0);
        step();
        drive(4'd0, 4'd1, 4'd0, 4'd0, 4'd6);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL r0_in_ready got=%b exp=1", in_ready); end
        step();
        idle();
        total++; if (ex_valid !== 1'b1 || ex_alu_op !== 6'd1) begin bad++; $display("FAIL r0_no_bubble got=%b/%0d exp=1/1", ex_valid, ex_alu_op); end
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL r0_stall_count got=%0d exp=1", stall_count); end
        repeat (3) step();
    endtask

    task automatic test_flush();
        drive(4'd6, 4'd2, 4'd1, 4'd2, 4'd0);
        step();
        total++; if (ex_alu_op !== 6'd18 || ex_br !== 1'b1) begin bad++; $display("FAIL fl_branch_ex got=%0d/%b exp=18/1", ex_alu_op, ex_br); end
        drive(4'd0, 4'd1, 4'd1, 4'd2, 4'd3);
        flush = 1;
        step();
        total++; if (ex_valid !== 1'b0 || ex_br !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%b/%b exp=0/0", ex_valid, ex_br); end
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL fl_mem_adv got=%b exp=1", mem_valid); end
        flush = 0;
        step();
        idle();
        total++; if (ex_valid !== 1'b1 || ex_alu_op !== 6'd1) begin bad++; $display("FAIL fl_reaccept got=%b/%0d exp=1/1", ex_valid, ex_alu_op); end
        repeat (3) step();
    endtask

    task automatic test_stall();
        drive(4'd8, 4'd3, 4'd1, 4'd0, 4'd5);
        step();
        drive(4'd5, 4'd4, 4'd1, 4'd2, 4'd7);
        step();
        drive(4'd10, 4'd1, 4'd1, 4'd0, 4'd8);
        stall = 1; flush = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ex_valid !== 1'b1 || ex_alu_op !== 6'd4 || ex_alu_src !== 1'b1)
                begin bad++; $display("FAIL st_ex_hold%0d got=%b/%0d/%b exp=1/4/1", i, ex_valid, ex_alu_op, ex_alu_src); end
            total++; if (mem_valid !== 1'b1 || mem_write !== 1'b0 || wb_valid !== 1'b0)
                begin bad++; $display("FAIL st_mw_hold%0d got=%b%b%b exp=100", i, mem_valid, mem_write, wb_valid); end
        end
        stall = 0; flush = 0;
        step();
        idle();
        total++; if (ex_valid !== 1'b1 || ex_alu_op !== 6'd17) begin bad++; $display("FAIL st_cmpi_ex got=%b/%0d exp=1/17", ex_valid, ex_alu_op); end
        total++; if (mem_valid !== 1'b1 || mem_write !== 1'b1) begin bad++; $display("FAIL st_sw_mem got=%b%b exp=11", mem_valid, mem_write); end
        total++; if (wb_reg_write !== 1'b1 || wb_rd !== 4'd5) begin bad++; $display("FAIL st_alui_wb got=%b/%0d exp=1/5", wb_reg_write, wb_rd); end
        step();
        total++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_reg_src !== 1'b1)
            begin bad++; $display("FAIL st_sw_wb got=%b%b%b exp=101", wb_valid, wb_reg_write, wb_reg_src); end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops  [5];
        logic [5:0] alu  [5];
        logic       src  [5];
        logic       rdm  [5];
        ops = '{4'd0, 4'd2, 4'd11, 4'd9, 4'd10};
        alu = '{6'd5, 6'd21, 6'd32, 6'd5, 6'd21};
        src = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rdm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 4'd5, 4'd1, 4'd2, 4'd3);
            step();
            total++; if (ex_valid !== 1'b1 || ex_alu_op !== alu[i] || ex_alu_src !== src[i])
                begin bad++; $display("FAIL b2b_ex%0d got=%b/%0d/%b exp=1/%0d/%b", i, ex_valid, ex_alu_op, ex_alu_src, alu[i], src[i]); end
            if (i > 0) begin
                total++; if (mem_valid !== 1'b1 || mem_read !== rdm[i-1])
                    begin bad++; $display("FAIL b2b_mem%0d got=%b%b exp=1%b", i, mem_valid, mem_read, rdm[i-1]); end
            end
        end
        idle();
        repeat (3) step();
    endtask

    task automatic test_illegal();
        drive(4'd15, 4'd1, 4'd1, 4'd2, 4'd3);
        step();
        idle();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL ill_ex_valid got=%b exp=0", ex_valid); end
`ifdef ILLEGAL_TRAP_EN
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%b exp=1", illegal_op); end
`else
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_pulse got=%b exp=0", illegal_op); end
`endif
        step();
        total++; if (illegal_op !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL ill_after got=%b%b exp=00", illegal_op, mem_valid); end
        repeat (2) step();
    endtask

    task automatic test_async_reset();
        drive(4'd8, 4'd3, 4'd1, 4'd0, 4'd5);
        step();
        step();
        idle();
        #2;
        reset_n = 0;
        #1;
        total++; if (ex_valid !== 1'b0 || mem_valid !== 1'b0 || wb_valid !== 1'b0)
            begin bad++; $display("FAIL ar_valids got=%b%b%b exp=000", ex_valid, mem_valid, wb_valid); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL ar_stall_count got=%0d exp=0", stall_count); end
        @(negedge clk);
        reset_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_alui_latency();
        test_load_use();
        test_load_r0();
        test_flush();
        test_stall();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
